// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol sequencer.
// State encoding, symbol encoding and fixed unit counts live here so the
// top level and the unit timer agree on them.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    MARK     = 3'd2,
    SPACE    = 3'd3,
    CHAR_GAP = 3'd4,
    END      = 3'd5
  } morse_state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int DOT_UNITS      = 1;
  localparam int CHAR_GAP_UNITS = 3;

  // Largest of three unit counts; sizes the shared unit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_unit_timer.sv
// Unit timer: loads a tick count, decrements once per tick_i and flags
// expire_o on the tick that consumes the last unit (count == 1).
// A load takes priority over a decrement, so the next interval can be
// loaded on the very tick that ends the current one.
module morse_unit_timer #(
  parameter int CNT_W = 2
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins, otherwise count down on ticks and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = tick_i && (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer: accepts one character (up to MAX_SYMBOLS dots or
// dashes, bit 0 first) via start/busy/done and keys led_o in whole ticks.
// Optional build macro MORSE_CHAR_GAP_EN appends a 3-unit dark gap after the
// last mark before done_o, so chained characters are spaced correctly.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 4,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1,
  parameter int LEN_W       = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   tick_i,
  input  logic                   start_i,
  input  logic [MAX_SYMBOLS-1:0] code_i,
  input  logic [LEN_W-1:0]       len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   led_o
);

  localparam int CNT_W = $clog2(max3(DASH_UNITS, GAP_UNITS, CHAR_GAP_UNITS) + 1);

  morse_state_e           state_q, state_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic                   led_q, led_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   load_s;
  logic [CNT_W-1:0]       load_val_s;
  logic                   expire_s;
  logic                   cur_sym_s;
  logic                   last_sym_s;
  logic [LEN_W-1:0]       len_clamped_s;
  logic [CNT_W-1:0]       sym_units_s;

  morse_unit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .expire_o   (expire_s)
  );

  // Select the symbol at the current index and its on-time in units.
  always_comb begin
    cur_sym_s = SYM_DOT;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      cur_sym_s = (idx_q == LEN_W'(i)) ? code_q[i] : cur_sym_s;
    end
    sym_units_s   = (cur_sym_s == SYM_DASH) ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);
    last_sym_s    = ((idx_q + LEN_W'(1)) == len_q);
    len_clamped_s = (len_i > LEN_W'(MAX_SYMBOLS)) ? LEN_W'(MAX_SYMBOLS) : len_i;
  end

  // Next-state logic: every led_o/busy_o/done_o change is decided on the
  // qualifying tick and becomes visible one refclk later via the registers.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    len_d      = len_q;
    idx_d      = idx_q;
    led_d      = led_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    load_val_s = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == {LEN_W{1'b0}}) begin
            done_d  = 1'b1;
            state_d = END;
          end else begin
            code_d  = code_i;
            len_d   = len_clamped_s;
            idx_d   = {LEN_W{1'b0}};
            busy_d  = 1'b1;
            state_d = SYNC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        // The start cycle's tick is not consumed: first mark waits for a fresh tick.
        if (tick_i) begin
          led_d      = 1'b1;
          load_s     = 1'b1;
          load_val_s = sym_units_s;
          state_d    = MARK;
        end else begin
          state_d = SYNC;
        end
      end
      MARK: begin
        if (expire_s) begin
          led_d = 1'b0;
          if (last_sym_s) begin
`ifdef MORSE_CHAR_GAP_EN
            load_s     = 1'b1;
            load_val_s = CNT_W'(CHAR_GAP_UNITS);
            state_d    = CHAR_GAP;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = END;
`endif
          end else begin
            idx_d      = idx_q + LEN_W'(1);
            load_s     = 1'b1;
            load_val_s = CNT_W'(GAP_UNITS);
            state_d    = SPACE;
          end
        end else begin
          state_d = MARK;
        end
      end
      SPACE: begin
        // idx_q already points at the next symbol here.
        if (expire_s) begin
          led_d      = 1'b1;
          load_s     = 1'b1;
          load_val_s = sym_units_s;
          state_d    = MARK;
        end else begin
          state_d = SPACE;
        end
      end
      CHAR_GAP: begin
        if (expire_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = END;
        end else begin
          state_d = CHAR_GAP;
        end
      end
      END: begin
        // done_o is high during this state; one cycle later a new start is taken.
        state_d = IDLE;
      end
      default: begin
        led_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any character without a done pulse.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= {MAX_SYMBOLS{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      idx_q   <= {LEN_W{1'b0}};
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign led_o  = led_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Bench for morse_symbol_sequencer. Expected waveforms come from a tick
// schedule: each mark/space boundary is the N-th tick after the previous
// boundary, and every output edge lands one refclk after that tick.
module tb_morse_symbol_sequencer;

  localparam int MAX_SYMBOLS = 4;
  localparam int DASH_UNITS  = 3;
  localparam int GAP_UNITS   = 1;
  localparam int LEN_W       = $clog2(MAX_SYMBOLS + 1);
  localparam int MAXP        = 30000;
  localparam int DIR_END     = 3000;
`ifdef MORSE_CHAR_GAP_EN
  localparam int TAIL_UNITS  = 3;
`else
  localparam int TAIL_UNITS  = 0;
`endif

  logic                   refclk  = 1'b0;
  logic                   rst_n   = 1'b0;
  logic                   tick_i  = 1'b0;
  logic                   start_i = 1'b0;
  logic [MAX_SYMBOLS-1:0] code_i  = '0;
  logic [LEN_W-1:0]       len_i   = '0;
  logic                   busy_o, done_o, led_o;

  int checks = 0;
  int errors = 0;
  int pe     = 0;          // number of rising edges so far
  bit chk_en = 1'b0;
  int ready_pe = 0;        // earliest rising edge at which a start is accepted
  int last_s, last_done, first_rise, last_fall;
  int runs[$];

  bit tick_at  [MAXP];
  bit exp_led  [MAXP];
  bit exp_busy [MAXP];
  bit exp_done [MAXP];
  bit obs_led  [MAXP];
  bit obs_busy [MAXP];
  bit obs_done [MAXP];

  morse_symbol_sequencer dut (
    .refclk  (refclk),
    .rst_n   (rst_n),
    .tick_i  (tick_i),
    .start_i (start_i),
    .code_i  (code_i),
    .len_i   (len_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .led_o   (led_o)
  );

  always #5 refclk = ~refclk;

  initial forever begin
    @(posedge refclk);
    pe++;
  end

  // tick_i for the coming rising edge, from the precomputed schedule.
  initial forever begin
    @(negedge refclk);
    #1;
    tick_i = (pe + 1 < MAXP) ? tick_at[pe + 1] : 1'b0;
  end

  // Compare process: every cycle against the model arrays.
  initial forever begin
    @(negedge refclk);
    if (chk_en && pe < MAXP) begin
      obs_led[pe]  = led_o;
      obs_busy[pe] = busy_o;
      obs_done[pe] = done_o;
      checks++;
      if (led_o !== exp_led[pe] || busy_o !== exp_busy[pe] || done_o !== exp_done[pe]) begin
        errors++;
        $display("FAIL cycle pe=%0d led/busy/done got %b%b%b expected %b%b%b",
                 pe, led_o, busy_o, done_o, exp_led[pe], exp_busy[pe], exp_done[pe]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge refclk);
    #1;
  endtask

  // Rising-edge index of the n-th tick strictly after edge p (-1 past the horizon).
  function automatic int nth_tick(input int p, input int n);
    int q;
    int k;
    q = p;
    k = 0;
    while (k < n) begin
      q++;
      if (q >= MAXP) return -1;
      if (tick_at[q]) k++;
    end
    return q;
  endfunction

  // Reference model: fill expected outputs for a start accepted at edge s.
  task automatic model_accept(input int s, input logic [MAX_SYMBOLS-1:0] code, input int len_raw);
    int len, cur, fall, fin, u;
    len = (len_raw > MAX_SYMBOLS) ? MAX_SYMBOLS : len_raw;
    last_s = s;
    if (len == 0) begin
      exp_done[s] = 1'b1;
      last_done = s;
      ready_pe = s + 2;
      return;
    end
    cur  = nth_tick(s, 1);
    fall = cur;
    for (int j = 0; j < len; j++) begin
      if (cur < 0) break;
      u = code[j] ? DASH_UNITS : 1;
      fall = nth_tick(cur, u);
      if (fall < 0) break;
      for (int k = cur; k < fall; k++) exp_led[k] = 1'b1;
      if (j < len - 1) cur = nth_tick(fall, GAP_UNITS);
    end
    fin = (cur < 0 || fall < 0) ? -1 : nth_tick(fall, TAIL_UNITS);
    if (fin < 0) begin
      checks++;
      errors++;
      $display("FAIL model_horizon start=%0d got no tick schedule expected one", s);
      ready_pe = MAXP;
      return;
    end
    for (int k = s; k < fin; k++) exp_busy[k] = 1'b1;
    exp_done[fin] = 1'b1;
    last_done = fin;
    ready_pe = fin + 2;
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (pe + 1 < ready_pe && budget < 3000) begin
      step();
      budget++;
    end
    if (pe + 1 < ready_pe) begin
      chk("wait_ready_timeout", pe, ready_pe);
      $fatal(1, "bench stuck waiting for ready");
    end
  endtask

  task automatic send(input logic [MAX_SYMBOLS-1:0] code, input int len);
    wait_ready();
    start_i = 1'b1;
    code_i  = code;
    len_i   = LEN_W'(len);
    model_accept(pe + 1, code, len);
    step();
    start_i = 1'b0;
    code_i  = MAX_SYMBOLS'($urandom);
    len_i   = LEN_W'($urandom);
  endtask

  // Extract alternating led_o run lengths from the first rise up to edge d.
  task automatic analyse(input int s, input int d);
    int cur_len;
    bit v;
    runs.delete();
    first_rise = -1;
    last_fall  = -1;
    cur_len = 0;
    v = 1'b0;
    for (int p = s; p <= d; p++) begin
      if (first_rise < 0) begin
        if (obs_led[p]) begin
          first_rise = p;
          v = 1'b1;
          cur_len = 1;
        end
      end else if (obs_led[p] == v) begin
        cur_len++;
      end else begin
        runs.push_back(cur_len);
        if (v) last_fall = p;
        v = obs_led[p];
        cur_len = 1;
      end
    end
  endtask

  task automatic check_runs(input string name, input int n, input int w[8]);
    chk($sformatf("%s_nruns", name), runs.size(), n);
    for (int i = 0; i < n && i < runs.size(); i++) begin
      chk($sformatf("%s_run%0d", name, i), runs[i], w[i]);
    end
  endtask

  function automatic int count_ones_done(input int a, input int b);
    int c;
    c = 0;
    for (int p = a; p <= b; p++) c += int'(obs_done[p]);
    return c;
  endfunction

  function automatic int count_ones_led(input int a, input int b);
    int c;
    c = 0;
    for (int p = a; p <= b; p++) c += int'(obs_led[p]);
    return c;
  endfunction

  function automatic int count_busy_low(input int a, input int b);
    int c;
    c = 0;
    for (int p = a; p <= b; p++) c += int'(!obs_busy[p]);
    return c;
  endfunction

  // Full-character checks shared by the directed cases.
  task automatic check_char(input string name, input int n, input int w[8]);
    wait_ready();
    analyse(last_s, last_done);
    check_runs(name, n, w);
    chk({name, "_done_count"}, count_ones_done(last_s, last_done + 1), 1);
    chk({name, "_busy_gaps"}, count_busy_low(last_s, last_done - 1), 0);
    chk({name, "_busy_at_done"}, int'(obs_busy[last_done]), 0);
    chk({name, "_done_after_fall"}, last_done - last_fall, TAIL_UNITS * 10);
    chk({name, "_led_in_tail"}, count_ones_led(last_fall, last_done), 0);
  endtask

  initial begin
    int mode, per, dens, budget;
    for (int p = 0; p < MAXP; p++) tick_at[p] = (p % 10 == 0);
    for (int b = DIR_END; b < MAXP; b += 150) begin
      mode = $urandom_range(0, 2);
      per  = $urandom_range(1, 12);
      dens = $urandom_range(1, 6);
      for (int p = b; p < b + 150 && p < MAXP; p++) begin
        case (mode)
          0:       tick_at[p] = (p % per == 0);
          1:       tick_at[p] = ($urandom_range(1, dens) == 1);
          default: tick_at[p] = 1'b1;
        endcase
      end
    end

    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_led", int'(led_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    ready_pe = pe + 1;

    // E
    send(4'b0000, 1);
    check_char("E", 1, '{10, 0, 0, 0, 0, 0, 0, 0});
    chk("E_rise_after_tick", first_rise, ((last_s / 10) + 1) * 10);

    // A
    send(4'b0010, 2);
    check_char("A", 3, '{10, 10, 30, 0, 0, 0, 0, 0});

    // Q
    send(4'b1011, 4);
    check_char("Q", 7, '{30, 10, 30, 10, 10, 10, 30, 0});

    // len = 0: done next cycle, nothing else moves
    send(4'b1111, 0);
    wait_ready();
    chk("len0_done", int'(obs_done[last_s]), 1);
    chk("len0_busy", int'(obs_busy[last_s]), 0);
    chk("len0_led", count_ones_led(last_s, last_s + 1), 0);

    // A with a stray start mid-character
    send(4'b0010, 2);
    repeat (25) step();
    start_i = 1'b1;
    code_i  = 4'b1111;
    len_i   = LEN_W'(4);
    repeat (2) step();
    start_i = 1'b0;
    check_char("A_stray", 3, '{10, 10, 30, 0, 0, 0, 0, 0});

    // T aborted by reset during the dash
    send(4'b0001, 1);
    budget = 0;
    while (led_o !== 1'b1 && budget < 200) begin
      step();
      budget++;
    end
    chk("T_led_rose", int'(led_o), 1);
    repeat (5) step();
    rst_n = 1'b0;
    for (int p = pe + 1; p < MAXP; p++) begin
      exp_led[p]  = 1'b0;
      exp_busy[p] = 1'b0;
      exp_done[p] = 1'b0;
    end
    #1;
    chk("T_async_led", int'(led_o), 0);
    chk("T_async_busy", int'(busy_o), 0);
    repeat (3) step();
    rst_n = 1'b1;
    ready_pe = pe + 1;

    // T again, runs normally
    send(4'b0001, 1);
    check_char("T", 1, '{30, 0, 0, 0, 0, 0, 0, 0});

    // start on a tick edge: that tick is not used
    wait_ready();
    while ((pe + 1) % 10 != 0) step();
    send(4'b0000, 1);
    check_char("E_on_tick", 1, '{10, 0, 0, 0, 0, 0, 0, 0});
    chk("E_on_tick_rise", first_rise, last_s + 10);

    // Randomized characters over varied tick patterns
    for (int n = 0; n < 70; n++) begin
      if (pe > MAXP - 1500) break;
      repeat ($urandom_range(0, 6)) step();
      send(MAX_SYMBOLS'($urandom), $urandom_range(0, 7));
      while (pe + 1 < ready_pe) begin
        start_i = $urandom_range(0, 3) == 0;
        code_i  = MAX_SYMBOLS'($urandom);
        len_i   = LEN_W'($urandom);
        step();
      end
      start_i = 1'b0;
    end

    wait_ready();
    repeat (5) step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
